srl_fifo_mc: RTL and testbench

Parametrised multi-channel FIFO built on shift-register (SRL) storage, the successor to the single-channel start/stream shift-register primitive. Provides NUM_CH independent FWFT FIFOs with HLS-style full_n/empty_n handshakes, occupancy count and almost-full flag. Used between kernel stages (e.g. PE start tokens, packed operand streams) where several narrow, shallow FIFOs share one clock.

---
 rtl/srl_fifo_pkg.sv | 19 +
 rtl/srl_fifo_ch.sv | 104 ++++++++++
 rtl/srl_fifo_mc.sv | 54 +++++
 tb/tb_srl_fifo_mc.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/srl_fifo_pkg.sv
// Shared types and helpers for the multi-channel SRL FIFO.
// Build option: define SRL_FIFO_HWM_EN to add the per-channel high-water-mark output.
package srl_fifo_pkg;

  localparam int unsigned DEPTH_MAX = 64;

  typedef int unsigned ch_idx_t;

  // Width needed to hold an occupancy in the range 0..depth.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  // Low bit of channel ch in a bus packed as NUM_CH slices of width bits.
  function automatic int unsigned slice_lo(input ch_idx_t ch, input int unsigned width);
    return ch * width;
  endfunction

endpackage

// File: rtl/srl_fifo_ch.sv
// One FWFT channel: shift-register storage, registered count, read address and flags.
// Build option: SRL_FIFO_HWM_EN adds hwm_o, the maximum registered count since reset.
module srl_fifo_ch
  import srl_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4,
  parameter int AF_THRESH  = 3,
  localparam int CNT_W     = cnt_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  write_i,
  input  logic [DATA_WIDTH-1:0] din_i,
  output logic                  full_n_o,
  input  logic                  read_i,
  output logic [DATA_WIDTH-1:0] dout_o,
  output logic                  empty_n_o,
  output logic                  almost_full_o,
  output logic [CNT_W-1:0]      count_o
`ifdef SRL_FIFO_HWM_EN
  ,
  output logic [CNT_W-1:0]      hwm_o
`endif
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  AF_C      = CNT_W'(AF_THRESH);
  localparam logic [ADDR_W-1:0] ADDR_MAX  = ADDR_W'(DEPTH - 1);
  localparam bit                PARAMS_OK = (DEPTH >= 2) && (DEPTH <= DEPTH_MAX) &&
                                            (AF_THRESH >= 1) && (AF_THRESH <= DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [CNT_W-1:0]      count_q, count_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic                  full_n_q, empty_n_q, af_q;
  logic                  push_acc, pop_acc;

  assign push_acc = write_i & full_n_q;
  assign pop_acc  = read_i & empty_n_q;

  // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    count_d = count_q;
    if (push_acc && !pop_acc) begin
      count_d = count_q + 1'b1;
    end else if (pop_acc && !push_acc) begin
      count_d = count_q - 1'b1;
    end
    addr_d = (count_d != '0) ? ADDR_W'(count_d - 1'b1) : '0;
  end

  // NOTE: storage has no reset; contents are don't-care until count says otherwise.
  always_ff @(posedge clk) begin
    if (push_acc) begin
      // NOTE: non-blocking so every slot shifts from its pre-edge neighbour.
      mem_q[0] <= din_i;
      for (int i = 1; i < DEPTH; i++) begin
        mem_q[i] <= mem_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q   <= '0;
      addr_q    <= '0;
      full_n_q  <= 1'b1;
      empty_n_q <= 1'b0;
      af_q      <= 1'b0;
    end else begin
      count_q   <= count_d;
      addr_q    <= addr_d;
      full_n_q  <= (count_d != DEPTH_C);
      empty_n_q <= (count_d != '0);
      af_q      <= (count_d >= AF_C);
    end
  end

`ifdef SRL_FIFO_HWM_EN
  logic [CNT_W-1:0] hwm_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hwm_q <= '0;
    end else if (count_q > hwm_q) begin
      hwm_q <= count_q;
    end
  end

  assign hwm_o = hwm_q;
`endif

  assign dout_o        = mem_q[addr_q];
  assign full_n_o      = full_n_q;
  assign empty_n_o     = empty_n_q;
  assign almost_full_o = af_q;
  assign count_o       = count_q;

  a_in_range: assert property (@(posedge clk) disable iff (!reset_n)
    PARAMS_OK && (count_q <= DEPTH_C) && (addr_q <= ADDR_MAX));

endmodule

// File: rtl/srl_fifo_mc.sv
// NUM_CH independent SRL FIFO channels sharing one clock; buses are packed per channel.
// Build option: SRL_FIFO_HWM_EN adds if_hwm with a per-channel high-water mark.
module srl_fifo_mc
  import srl_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4,
  parameter int NUM_CH     = 2,
  parameter int AF_THRESH  = 3,
  localparam int CNT_W     = cnt_width(DEPTH)
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [NUM_CH-1:0]            if_write,
  input  logic [NUM_CH*DATA_WIDTH-1:0] if_din,
  output logic [NUM_CH-1:0]            if_full_n,
  input  logic [NUM_CH-1:0]            if_read,
  output logic [NUM_CH*DATA_WIDTH-1:0] if_dout,
  output logic [NUM_CH-1:0]            if_empty_n,
  output logic [NUM_CH-1:0]            if_almost_full,
  output logic [NUM_CH*CNT_W-1:0]      if_count
`ifdef SRL_FIFO_HWM_EN
  ,
  output logic [NUM_CH*CNT_W-1:0]      if_hwm
`endif
);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    localparam int unsigned DLO = slice_lo(ch_idx_t'(c), DATA_WIDTH);
    localparam int unsigned CLO = slice_lo(ch_idx_t'(c), CNT_W);

    srl_fifo_ch #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .AF_THRESH  (AF_THRESH)
    ) u_ch (
      .clk           (clk),
      .reset_n       (reset_n),
      .write_i       (if_write[c]),
      .din_i         (if_din[DLO +: DATA_WIDTH]),
      .full_n_o      (if_full_n[c]),
      .read_i        (if_read[c]),
      .dout_o        (if_dout[DLO +: DATA_WIDTH]),
      .empty_n_o     (if_empty_n[c]),
      .almost_full_o (if_almost_full[c]),
      .count_o       (if_count[CLO +: CNT_W])
`ifdef SRL_FIFO_HWM_EN
      ,
      .hwm_o         (if_hwm[CLO +: CNT_W])
`endif
    );
  end

endmodule

// File: tb/tb_srl_fifo_mc.sv
// Randomised and directed bench for srl_fifo_mc against a queue-based model.
// Build option: SRL_FIFO_HWM_EN also checks if_hwm.
module tb_srl_fifo_mc;

  localparam int DW  = 8;
  localparam int DEP = 4;
  localparam int NCH = 2;
  localparam int AF  = 3;
  localparam int CW  = $clog2(DEP + 1);

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [NCH-1:0]    if_write = '0;
  logic [NCH*DW-1:0] if_din = '0;
  logic [NCH-1:0]    if_full_n;
  logic [NCH-1:0]    if_read = '0;
  logic [NCH*DW-1:0] if_dout;
  logic [NCH-1:0]    if_empty_n;
  logic [NCH-1:0]    if_almost_full;
  logic [NCH*CW-1:0] if_count;
`ifdef SRL_FIFO_HWM_EN
  logic [NCH*CW-1:0] if_hwm;
  int                hwm_m [NCH];
`endif

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;
  logic [DW-1:0] mq [NCH][$];

  srl_fifo_mc #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEP),
    .NUM_CH     (NCH),
    .AF_THRESH  (AF)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .if_write       (if_write),
    .if_din         (if_din),
    .if_full_n      (if_full_n),
    .if_read        (if_read),
    .if_dout        (if_dout),
    .if_empty_n     (if_empty_n),
    .if_almost_full (if_almost_full),
    .if_count       (if_count)
`ifdef SRL_FIFO_HWM_EN
    ,
    .if_hwm         (if_hwm)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; the model advances from its pre-edge occupancy.
  task automatic step(input logic [NCH-1:0] wr, input logic [NCH*DW-1:0] din,
                      input logic [NCH-1:0] rd);
    if_write = wr;
    if_din   = din;
    if_read  = rd;
    @(posedge clk);
    for (int c = 0; c < NCH; c++) begin
      int  pre;
      bit  push, pop;
      pre  = mq[c].size();
      push = wr[c] && (pre < DEP);
      pop  = rd[c] && (pre > 0);
      if (pop)  void'(mq[c].pop_front());
      if (push) mq[c].push_back(din[c*DW +: DW]);
`ifdef SRL_FIFO_HWM_EN
      if (pre > hwm_m[c]) hwm_m[c] = pre;
`endif
    end
    #1;
    if_write = '0;
    if_read  = '0;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int c = 0; c < NCH; c++) begin
        check($sformatf("ch%0d_count", c), 32'(if_count[c*CW +: CW]), mq[c].size());
        check($sformatf("ch%0d_empty_n", c), 32'(if_empty_n[c]), 32'(mq[c].size() != 0));
        check($sformatf("ch%0d_full_n", c), 32'(if_full_n[c]), 32'(mq[c].size() != DEP));
        check($sformatf("ch%0d_af", c), 32'(if_almost_full[c]), 32'(mq[c].size() >= AF));
        if (mq[c].size() != 0)
          check($sformatf("ch%0d_dout", c), 32'(if_dout[c*DW +: DW]), 32'(mq[c][0]));
`ifdef SRL_FIFO_HWM_EN
        check($sformatf("ch%0d_hwm", c), 32'(if_hwm[c*CW +: CW]), hwm_m[c]);
`endif
      end
    end
  end

  initial begin
    logic [DW-1:0] lit [4];
    int wb, rb;
    logic [NCH-1:0] wr, rd;
`ifdef SRL_FIFO_HWM_EN
    hwm_m = '{default: 0};
`endif
    #12;
    reset_n = 1'b1;
    #1;
    // Reset then idle
    check("rst_empty_n", 32'(if_empty_n), 32'h0);
    check("rst_full_n", 32'(if_full_n), 32'h3);
    check("rst_count", 32'(if_count), 32'h0);
    check("rst_af", 32'(if_almost_full), 32'h0);
    chk_en = 1'b1;
    step('0, '0, '0);

    // Fill ch0, overflow push ignored, drain in order
    lit = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int k = 0; k < 4; k++) begin
      step(2'b01, {8'h00, lit[k]}, '0);
      check("fill_count0", 32'(if_count[CW-1:0]), k + 1);
      if (k == 2) check("fill_af0", 32'(if_almost_full[0]), 32'h1);
    end
    check("fill_full_n0", 32'(if_full_n[0]), 32'h0);
    step(2'b01, {8'h00, 8'h55}, '0);
    check("ovf_count0", 32'(if_count[CW-1:0]), 32'd4);
    check("ovf_count1", 32'(if_count[2*CW-1:CW]), 32'd0);
    for (int k = 0; k < 4; k++) begin
      check("drain_dout0", 32'(if_dout[DW-1:0]), 32'(lit[k]));
      step('0, '0, 2'b01);
    end
    check("drain_empty_n0", 32'(if_empty_n[0]), 32'h0);

    // Simultaneous push+pop at count 2
    step(2'b01, {8'h00, 8'hA1}, '0);
    step(2'b01, {8'h00, 8'hA2}, '0);
    check("pp_head", 32'(if_dout[DW-1:0]), 32'hA1);
    step(2'b01, {8'h00, 8'hA3}, 2'b01);
    check("pp_count", 32'(if_count[CW-1:0]), 32'd2);
    check("pp_head2", 32'(if_dout[DW-1:0]), 32'hA2);
    step('0, '0, 2'b01);
    check("pp_head3", 32'(if_dout[DW-1:0]), 32'hA3);
    step('0, '0, 2'b01);

    // Full boundary: write+read accepts only the pop
    for (int k = 0; k < 4; k++) step(2'b01, {8'h00, 8'(8'hB0 + k)}, '0);
    step(2'b01, {8'h00, 8'hCC}, 2'b01);
    check("fb_count", 32'(if_count[CW-1:0]), 32'd3);
    check("fb_full_n", 32'(if_full_n[0]), 32'h1);
    for (int k = 1; k < 4; k++) begin
      check("fb_dout", 32'(if_dout[DW-1:0]), 32'(8'hB0 + k));
      step('0, '0, 2'b01);
    end
    check("fb_empty", 32'(if_empty_n[0]), 32'h0);

    // Empty boundary: write+read accepts only the push
    step(2'b01, {8'h00, 8'h5A}, 2'b01);
    check("eb_count", 32'(if_count[CW-1:0]), 32'd1);
    check("eb_empty_n", 32'(if_empty_n[0]), 32'h1);
    check("eb_dout", 32'(if_dout[DW-1:0]), 32'h5A);
    step('0, '0, 2'b01);

    // Mid-cycle asynchronous reset at count 3
    for (int k = 0; k < 3; k++) step(2'b01, {8'h00, 8'(8'hC1 + k)}, '0);
    step('0, '0, '0);
`ifdef SRL_FIFO_HWM_EN
    check("hwm_pre", 32'(if_hwm[CW-1:0]), 32'd3);
`endif
    #2;
    chk_en  = 1'b0;
    reset_n = 1'b0;
    #1;
    check("ar_empty_n", 32'(if_empty_n), 32'h0);
    check("ar_full_n", 32'(if_full_n), 32'h3);
    check("ar_count", 32'(if_count), 32'h0);
    check("ar_af", 32'(if_almost_full), 32'h0);
    for (int c = 0; c < NCH; c++) mq[c].delete();
`ifdef SRL_FIFO_HWM_EN
    hwm_m = '{default: 0};
`endif
    @(posedge clk);
    #3;
    reset_n = 1'b1;
    chk_en  = 1'b1;
    @(posedge clk);
    #1;
    step(2'b01, {8'h00, 8'h7E}, '0);
    check("pr_count", 32'(if_count[CW-1:0]), 32'd1);
    check("pr_dout", 32'(if_dout[DW-1:0]), 32'h7E);
    step('0, '0, '0);
`ifdef SRL_FIFO_HWM_EN
    check("hwm_post", 32'(if_hwm[CW-1:0]), 32'd1);
`endif

    // Random traffic with per-segment write/read bias
    for (int seg = 0; seg < 20; seg++) begin
      wb = $urandom_range(0, 4);
      rb = $urandom_range(0, 4);
      for (int n = 0; n < 100; n++) begin
        for (int c = 0; c < NCH; c++) begin
          wr[c] = ($urandom_range(0, 3) < wb);
          rd[c] = ($urandom_range(0, 3) < rb);
        end
        step(wr, NCH*DW'($urandom), rd);
      end
    end

    step('0, '0, '0);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
